card_deck: RTL and testbench

Card source for the Black Jack datapath. It holds a single 52-card deck as a dealt-card bitmap and draws pseudo-random undealt cards from a free-running 8-bit LFSR. On each accepted request it emits one card value (ace = 1, faces = 10) as a single-cycle valid strobe. It sits directly upstream of the game FSM, replacing the free-running card generator, and guarantees no repeated card until the deck is reshuffled.

---
 rtl/bj_pkg.sv | 27 ++
 rtl/card_deck_lfsr8.sv | 18 +
 rtl/card_deck.sv | 104 ++++++++++
 tb/tb_card_deck.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bj_pkg.sv
// Shared deck constants, FSM state encoding and the index-to-card-value mapping
// used by both the card source and its scoreboard.
package bj_pkg;

  localparam int DECK_SIZE = 52;
  localparam int SUIT_SIZE = 13;
  localparam int ACE_VALUE = 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHUFFLE = 3'd1,
    ST_DRAW    = 3'd2,
    ST_PROBE   = 3'd3,
    ST_DEAL    = 3'd4
  } deck_state_t;

  // rank 0 is the ace, ranks 9..12 are 10/J/Q/K
  function automatic logic [4:0] idx_to_value(input logic [5:0] idx,
                                              input logic [4:0] face);
    logic [5:0] rank;
    rank = idx % 6'(SUIT_SIZE);
    if (rank == 6'd0)      return 5'(ACE_VALUE);
    else if (rank <= 6'd8) return 5'(rank + 6'd1);
    else                   return face;
  endfunction

endpackage

// File: rtl/card_deck_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic fb;
  // an all-zero seed would lock the register, so it is replaced by 1
  assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (rst) q <= (seed == 8'h00) ? 8'h01 : seed;
    else     q <= {q[6:0], fb};
  end

endmodule

// File: rtl/card_deck.sv
// Single-deck card source: dealt-card bitmap plus LFSR draw with linear probing.
// CARD_DECK_SEED_EN adds a seed port that the LFSR loads while rst is high.
module card_deck
  import bj_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int         FACE_VALUE = 10
) (
  input  logic       clk,
  input  logic       rst,
`ifdef CARD_DECK_SEED_EN
  input  logic [7:0] seed,
`endif
  input  logic       req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [4:0] card,
  output logic [5:0] cards_left,
  output logic       busy,
  output logic       reshuffled
);

  deck_state_t              state;
  logic [DECK_SIZE-1:0]     used;
  logic [5:0]               idx;
  logic                     pending;
  logic [7:0]               lfsr;
  logic [7:0]               lfsr_seed;
  logic [5:0]               draw_idx;
  logic                     lfsr_unused;

`ifdef CARD_DECK_SEED_EN
  assign lfsr_seed = seed;
`else
  assign lfsr_seed = LFSR_SEED;
`endif

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (lfsr_seed),
    .q    (lfsr)
  );

  // fold 52..63 down to 0..11 so every draw lands inside the deck
  assign draw_idx    = (lfsr[5:0] >= 6'(DECK_SIZE)) ? lfsr[5:0] - 6'(DECK_SIZE)
                                                    : lfsr[5:0];
  assign lfsr_unused = ^lfsr[7:6];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      used       <= '0;
      cards_left <= 6'(DECK_SIZE);
      card       <= 5'd0;
      idx        <= 6'd0;
      pending    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (shuffle) begin
            state   <= ST_SHUFFLE;
            pending <= req;
          end else if (req) begin
            if (cards_left == 6'd0) begin
              state   <= ST_SHUFFLE;
              pending <= 1'b1;
            end else begin
              state <= ST_DRAW;
            end
          end
        end
        ST_SHUFFLE: begin
          used       <= '0;
          cards_left <= 6'(DECK_SIZE);
          pending    <= 1'b0;
          state      <= pending ? ST_DRAW : ST_IDLE;
        end
        ST_DRAW: begin
          idx   <= draw_idx;
          state <= ST_PROBE;
        end
        ST_PROBE: begin
          // walk forward with wrap until an undealt card is found
          if (used[idx]) begin
            idx <= (idx == 6'(DECK_SIZE - 1)) ? 6'd0 : idx + 6'd1;
          end else begin
            used[idx]  <= 1'b1;
            cards_left <= cards_left - 6'd1;
            card       <= idx_to_value(idx, 5'(FACE_VALUE));
            state      <= ST_DEAL;
          end
        end
        ST_DEAL:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign card_valid = (state == ST_DEAL);
  assign busy       = (state != ST_IDLE);
  assign reshuffled = (state == ST_SHUFFLE);

endmodule

// File: tb/tb_card_deck.sv
// Directed bench for card_deck: latency bounds, full-deck value histogram,
// empty-deck and forced reshuffle, busy-time request drop, mid-draw reset.
module tb_card_deck;
  import bj_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       shuffle = 1'b0;
  logic       card_valid;
  logic [4:0] card;
  logic [5:0] cards_left;
  logic       busy;
  logic       reshuffled;
`ifdef CARD_DECK_SEED_EN
  logic [7:0] seed = 8'h3C;
`endif

  int checks = 0;
  int errors = 0;
  int hist [11];
  logic [4:0] seq_a [5];
  logic [4:0] seq_b [5];

  card_deck dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CARD_DECK_SEED_EN
    .seed       (seed),
`endif
    .req        (req),
    .shuffle    (shuffle),
    .card_valid (card_valid),
    .card       (card),
    .cards_left (cards_left),
    .busy       (busy),
    .reshuffled (reshuffled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // pulse req in IDLE and wait (bounded) for the strobe; rs_at is the
  // cycle after acceptance where reshuffled was first seen, 0 if never
  task automatic draw(output int lat, output logic [4:0] val, output int rs_at);
    req = 1'b1;
    tick();
    req = 1'b0;
    lat = 1;
    rs_at = reshuffled ? 1 : 0;
    while (!card_valid && lat < 70) begin
      tick();
      lat++;
      if (reshuffled && rs_at == 0) rs_at = lat;
    end
    val = card;
  endtask

  function automatic int in_range(input int v, input int lo, input int hi);
    return (v >= lo && v <= hi) ? 1 : 0;
  endfunction

  initial begin
    int lat, rs_at, nval;
    logic [4:0] val;

    // reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_card", card, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_left", cards_left, 52);
    chk("rst_busy", busy, 0);
    chk("rst_reshuf", reshuffled, 0);

    // mapping function against hand-computed values
    chk("map0", idx_to_value(6'd0, 5'd10), 1);
    chk("map8", idx_to_value(6'd8, 5'd10), 9);
    chk("map9", idx_to_value(6'd9, 5'd10), 10);
    chk("map12", idx_to_value(6'd12, 5'd10), 10);
    chk("map13", idx_to_value(6'd13, 5'd10), 1);
    chk("map14", idx_to_value(6'd14, 5'd10), 2);
    chk("map25", idx_to_value(6'd25, 5'd10), 10);
    chk("map51", idx_to_value(6'd51, 5'd10), 10);

    // first card
    for (int i = 0; i < 11; i++) hist[i] = 0;
    draw(lat, val, rs_at);
    chk("first_lat", in_range(lat, 3, 54), 1);
    chk("first_val", in_range(val, 1, 10), 1);
    chk("first_left", cards_left, 51);
    tick();
    chk("first_busy", busy, 0);
    hist[val]++;

    // rest of the deck
    for (int i = 1; i < 52; i++) begin
      draw(lat, val, rs_at);
      chk("deck_lat", in_range(lat, 3, 54), 1);
      chk("deck_left", cards_left, 51 - i);
      if (in_range(val, 1, 10) == 1) hist[val]++;
      else chk("deck_val", val, 1);
      tick();
    end
    chk("empty_left", cards_left, 0);
    chk("hist_1", hist[1], 4);
    for (int v = 2; v <= 9; v++) chk($sformatf("hist_%0d", v), hist[v], 4);
    chk("hist_10", hist[10], 16);

    // request on an empty deck reshuffles first
    draw(lat, val, rs_at);
    chk("rs_at", rs_at, 1);
    chk("rs_lat", in_range(lat, 4, 55), 1);
    chk("rs_val", in_range(val, 1, 10), 1);
    chk("rs_left", cards_left, 51);
    tick();

    // nine more, then a forced shuffle
    for (int i = 0; i < 9; i++) begin
      draw(lat, val, rs_at);
      tick();
    end
    chk("pre_shuf_left", cards_left, 42);
    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    chk("shuf_pulse", reshuffled, 1);
    chk("shuf_busy", busy, 1);
    chk("shuf_valid", card_valid, 0);
    tick();
    chk("shuf_pulse_end", reshuffled, 0);
    chk("shuf_left", cards_left, 52);
    chk("shuf_idle", busy, 0);
    nval = 0;
    for (int i = 0; i < 5; i++) begin
      if (card_valid) nval++;
      tick();
    end
    chk("shuf_no_card", nval, 0);

    // req while busy is dropped
    req = 1'b1;
    tick();
    tick();
    req = 1'b0;
    nval = 0;
    for (int i = 0; i < 60; i++) begin
      if (card_valid) nval++;
      tick();
    end
    chk("busy_req_cards", nval, 1);
    chk("busy_req_left", cards_left, 51);

    // reset while in PROBE
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("probe_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_card", card, 0);
    chk("mid_rst_valid", card_valid, 0);
    chk("mid_rst_left", cards_left, 52);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_reshuf", reshuffled, 0);
    nval = 0;
    for (int i = 0; i < 10; i++) begin
      if (card_valid) nval++;
      tick();
    end
    chk("mid_rst_no_card", nval, 0);

    // same seed and timing twice gives the same sequence
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      draw(lat, val, rs_at);
      seq_a[i] = val;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      draw(lat, val, rs_at);
      seq_b[i] = val;
      tick();
    end
    for (int i = 0; i < 5; i++) chk($sformatf("repeat_%0d", i), seq_b[i], seq_a[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
